// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 16x-oversampled UART transmitter (start, DBIT data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_unit #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE: if (tx_start) begin
                state_d = START;
                s_d     = '0;
                b_d     = din;
`ifdef UART_TX_PARITY_EN
                par_d   = ^din;
`endif
            end
            START: if (s_tick) begin
                if (s_q == SW'(15)) begin
                    state_d = DATA;
                    s_d     = '0;
                    n_d     = '0;
                end else s_d = s_q + 1'b1;
            end
            DATA: if (s_tick) begin
                if (s_q == SW'(15)) begin
                    s_d = '0;
                    b_d = b_q >> 1;
                    if (n_q == NW'(DBIT - 1))
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    else n_d = n_q + 1'b1;
                end else s_d = s_q + 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (s_tick) begin
                if (s_q == SW'(15)) begin
                    state_d = STOP;
                    s_d     = '0;
                end else s_d = s_q + 1'b1;
            end
`endif
            STOP: if (s_tick) begin
                if (s_q == SW'(SB_TICK - 1)) begin
                    state_d      = IDLE;
                    s_d          = '0;
                    tx_done_tick = 1'b1;
                end else s_d = s_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the next state so tx changes on the same edge as the state.
    always_comb begin
`ifdef UART_TX_PARITY_EN
        tx_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? b_d[0] :
               (state_d == PARITY) ? par_d : 1'b1;
`else
        tx_d = (state_d == START) ? 1'b0 :
               (state_d == DATA)  ? b_d[0] : 1'b1;
`endif
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: scoreboard bench; u0 uses SB_TICK=16, u1 uses SB_TICK=32 for sparse ticks.
module tb_uart_tx_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick0 = 1'b0, s_tick1 = 1'b0;
    logic       st0 = 1'b0, st1 = 1'b0;
    logic [7:0] din = '0;
    logic       busy0, done0, tx0, busy1, done1, tx1;
    logic       sel = 1'b0;
    logic       tx_m, done_m, busy_m;
    logic [1:0] exp_q[$];
    int         n_cmp = 0, n_bad = 0;

    uart_tx_unit #(.DBIT(8), .SB_TICK(16)) u0 (
        .clk(clk), .reset(reset), .s_tick(s_tick0), .tx_start(st0), .din(din),
        .tx_busy(busy0), .tx_done_tick(done0), .tx(tx0));
    uart_tx_unit #(.DBIT(8), .SB_TICK(32)) u1 (
        .clk(clk), .reset(reset), .s_tick(s_tick1), .tx_start(st1), .din(din),
        .tx_busy(busy1), .tx_done_tick(done1), .tx(tx1));

    always #5 clk = ~clk;
    assign tx_m   = sel ? tx1 : tx0;
    assign done_m = sel ? done1 : done0;
    assign busy_m = sel ? busy1 : busy0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, b});
    endtask

    // Accept d, then check every cycle of the frame against the queued line/done pattern.
    task automatic frame(input logic [7:0] d, input int per, input int sb, input logic s,
                         input int inj, input logic hold);
        logic [1:0] e;
        logic       tk;
        sel = s;
        din = d;
        if (s) st1 = 1'b1; else st0 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin st0 = 1'b0; st1 = 1'b0; end
        push_bit(1'b0, 16 * per);
        for (int i = 0; i < 8; i++) push_bit(d[i], 16 * per);
`ifdef UART_TX_PARITY_EN
        push_bit(^d, 16 * per);
`endif
        push_bit(1'b1, sb * per - 1);
        exp_q.push_back(2'b11);
        for (int j = 0; exp_q.size() > 0; j++) begin
            tk = ((j + 1) % per == 0);
            if (s) s_tick1 = tk; else s_tick0 = tk;
            if (j == inj) begin din = 8'hFF; if (s) st1 = 1'b1; else st0 = 1'b1; end
            else if (j == inj + 1 && !hold) begin st0 = 1'b0; st1 = 1'b0; end
            @(negedge clk);
            e = exp_q.pop_front();
            chk("tx", tx_m, e[0]);
            chk("done", done_m, e[1]);
            chk("busy", busy_m, 1'b1);
            @(posedge clk); #1;
        end
        s_tick0 = 1'b0;
        s_tick1 = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy_m, 1'b0);
        chk("idle_tx", tx_m, 1'b1);
    endtask

    initial begin
        st0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_tick0 = i[0];
            @(negedge clk);
            chk("rst_tx", tx0, 1'b1);
            chk("rst_busy", busy0, 1'b0);
            chk("rst_done", done0, 1'b0);
            chk("rst_tx1", tx1, 1'b1);
        end
        st0 = 1'b0;
        s_tick0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy0, 1'b0);
        chk("post_rst_tx", tx0, 1'b1);

        frame(8'hA5, 1, 16, 1'b0, -1, 1'b0);
        frame(8'h07, 1, 16, 1'b0, -1, 1'b0);
        frame(8'h03, 1, 16, 1'b0, -1, 1'b0);

        frame(8'h3A, 1, 16, 1'b0, 40, 1'b0);
        s_tick0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_second", busy0, 1'b0);
        end
        s_tick0 = 1'b0;

        frame(8'h5A, 1, 16, 1'b0, -1, 1'b1);
        frame(8'hC3, 1, 16, 1'b0, -1, 1'b1);
        frame(8'h81, 1, 16, 1'b0, -1, 1'b0);

        frame(8'h96, 10, 32, 1'b1, -1, 1'b0);

        sel = 1'b0;
        din = 8'hA5;
        st0 = 1'b1;
        @(posedge clk); #1;
        st0 = 1'b0;
        s_tick0 = 1'b1;
        repeat (70) @(posedge clk);
        #1;
        chk("mid_bit3", tx0, 1'b0);
        reset = 1'b0;
        #1;
        chk("abort_tx", tx0, 1'b1);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_done", done0, 1'b0);
        @(negedge clk);
        chk("abort_done2", done0, 1'b0);
        @(posedge clk); #1;
        s_tick0 = 1'b0;
        reset = 1'b1;
        frame(8'h3C, 1, 16, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
